// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit. Entries are allocated at the tail and
// completed out of order by write-back. They retire one per cycle from the
// head. Branch/exception/ERET redirects are issued as registered one-cycle
// pulses, and the buffer is flushed at the same edge.
module rob_commit #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned IDX_W      = $clog2(DEPTH),
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic [4:0]       alloc_dst,
  output logic [IDX_W-1:0] alloc_id,
  output logic             rob_full,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_id,
  input  logic [31:0]      wb_result,
  input  logic             wb_exc,
  input  logic [4:0]       wb_excode,
  input  logic             wb_br_taken,
  input  logic             wb_eret,
  input  logic [31:0]      wb_target,
  output logic             commit_valid,
  output logic [4:0]       commit_dst,
  output logic [31:0]      commit_data,
  output logic [31:0]      commit_pc,
  output logic             branch_taken,
  output logic             exception_valid,
  output logic             is_eret,
  output logic [31:0]      redirect_pc,
  output logic [4:0]       exc_code
);

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        exc;
    logic [4:0]  excode;
    logic        br;
    logic        eret;
    logic [31:0] target;
    logic [31:0] pc;
    logic [4:0]  dst;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {IDLE, WAIT_DS} state_t;

  localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   ONE_CNT    = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] ONE_IDX    = IDX_W'(1);

  entry_t           rob [DEPTH];
  entry_t           head_entry;
  entry_t           alloc_entry;
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count, count_next;
  logic [31:0]      ds_target;
  state_t           state, state_next;

  logic pulse, ready, accept, wb_hit;
  logic retire, clear, fire_exc, fire_eret, fire_br, latch_br;

  assign head_entry = rob[head];
  assign pulse      = branch_taken | exception_valid | is_eret;
  // During a redirect pulse the buffer is already empty and inputs are wrong-path.
  assign ready      = head_entry.valid & head_entry.done & ~pulse;
  assign accept     = alloc_valid & ~rob_full & ~pulse;
  assign wb_hit     = wb_valid & rob[wb_id].valid & ~pulse;

  assign alloc_id     = tail;
  assign commit_valid = ready & ~head_entry.exc & ~head_entry.eret & (head_entry.dst != 5'd0);
  assign commit_dst   = head_entry.dst;
  assign commit_data  = head_entry.data;
  assign commit_pc    = head_entry.pc;

  // Commit FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Commit FSM next state: a taken branch parks in WAIT_DS until its delay slot retires.
  always_comb begin
    state_next = state;
    if (ready) begin
      case (state)
        IDLE:    if (!head_entry.exc && !head_entry.eret && head_entry.br) state_next = WAIT_DS;
        WAIT_DS: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Commit FSM outputs: retire/flush/redirect decisions for the head entry.
  always_comb begin
    retire    = 1'b0;
    clear     = 1'b0;
    fire_exc  = 1'b0;
    fire_eret = 1'b0;
    fire_br   = 1'b0;
    latch_br  = 1'b0;
    if (ready) begin
      case (state)
        IDLE: begin
          if (head_entry.exc) begin
            fire_exc = 1'b1;
            clear    = 1'b1;
          end else if (head_entry.eret) begin
            retire    = 1'b1;
            fire_eret = 1'b1;
            clear     = 1'b1;
          end else begin
            retire   = 1'b1;
            latch_br = head_entry.br;
          end
        end
        WAIT_DS: begin
          if (head_entry.exc) begin
            fire_exc = 1'b1;
            clear    = 1'b1;
          end else begin
            retire  = 1'b1;
            fire_br = 1'b1;
            clear   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Occupancy after this edge; a flush overrides alloc/retire.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else begin
      case ({accept, retire})
        2'b10:   count_next = count + ONE_CNT;
        2'b01:   count_next = count - ONE_CNT;
        default: count_next = count;
      endcase
    end
  end

  // Fresh entry written at the tail on an accepted allocation.
  always_comb begin
    alloc_entry       = '0;
    alloc_entry.valid = 1'b1;
    alloc_entry.pc    = alloc_pc;
    alloc_entry.dst   = alloc_dst;
  end

  // Entry storage, pointers, occupancy and registered redirect outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) rob[i] <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      rob_full        <= 1'b0;
      ds_target       <= '0;
      branch_taken    <= 1'b0;
      exception_valid <= 1'b0;
      is_eret         <= 1'b0;
      redirect_pc     <= '0;
      exc_code        <= '0;
    end else begin
      count           <= count_next;
      rob_full        <= (count_next == FULL_COUNT);
      branch_taken    <= fire_br;
      exception_valid <= fire_exc;
      is_eret         <= fire_eret;
      if (fire_exc) begin
        redirect_pc <= EXC_VECTOR;
        exc_code    <= head_entry.excode;
      end else if (fire_eret) begin
        redirect_pc <= head_entry.target;
      end else if (fire_br) begin
        redirect_pc <= ds_target;
      end
      if (latch_br) ds_target <= head_entry.target;
      if (clear) begin
        for (int unsigned i = 0; i < DEPTH; i++) rob[i].valid <= 1'b0;
        head <= '0;
        tail <= '0;
      end else begin
        if (wb_hit) begin
          rob[wb_id].done   <= 1'b1;
          rob[wb_id].data   <= wb_result;
          rob[wb_id].exc    <= wb_exc;
          rob[wb_id].excode <= wb_excode;
          rob[wb_id].br     <= wb_br_taken;
          rob[wb_id].eret   <= wb_eret;
          rob[wb_id].target <= wb_target;
        end
        if (retire) begin
          rob[head].valid <= 1'b0;
          head            <= head + ONE_IDX;
        end
        if (accept) begin
          rob[tail] <= alloc_entry;
          tail      <= tail + ONE_IDX;
        end
      end
    end
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer and in-order commit unit. It sits between rename/dispatch, the execute write-back ports and the register file. It allocates one entry per dispatched instruction and collects completions out of order. It retires entries in program order, and it is the producer of the `rob_full`, `branch_taken`, `exception_valid` and `is_eret` signals that the hazard unit turns into stalls and flushes.

## Interface
- `DEPTH`, default 8: number of entries; power of two, ≥ 4.
- `IDX_W`, default `$clog2(DEPTH)`: entry index width.
- `EXC_VECTOR`, default 32'hBFC0_0380: redirect target for exceptions.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `alloc_valid` in 1: dispatch presents an instruction.
- `alloc_pc` in 32: its PC.
- `alloc_dst` in 5: destination register (0 = none).
- `alloc_id` out IDX_W: index given to the instruction; equals the tail pointer.
- `rob_full` out 1: high when all DEPTH entries are valid.
- `wb_valid` in 1: an execute unit completes an entry.
- `wb_id` in IDX_W: the entry being completed.
- `wb_result` in 32: result value.
- `wb_exc` in 1: the instruction raised an exception.
- `wb_excode` in 5: exception code.
- `wb_br_taken` in 1: a branch resolved as mispredicted (redirect needed).
- `wb_eret` in 1: the instruction is ERET.
- `wb_target` in 32: branch target, or EPC for ERET.
- `commit_valid` out 1: register write at head.
- `commit_dst` out 5: head destination register.
- `commit_data` out 32: head result.
- `commit_pc` out 32: head PC.
- `branch_taken` out 1: one-cycle redirect pulse.
- `exception_valid` out 1: one-cycle redirect pulse.
- `is_eret` out 1: one-cycle redirect pulse.
- `redirect_pc` out 32: fetch target; valid while any pulse is high.
- `exc_code` out 5: valid with `exception_valid`.

## Operation
- Storage: circular array with head, tail and count (count is IDX_W+1 bits). Each entry holds valid, done, exc, excode, br, eret, target, pc, dst, data.
- Allocation is accepted iff `alloc_valid & ~rob_full & ~pulse`, where pulse = OR of the three redirect outputs.
  - On accept: write entry[tail] (valid=1, done=0), then tail+1 modulo DEPTH.
  - Otherwise the request is silently dropped.
- Write-back: if `wb_valid & entry[wb_id].valid & ~pulse`, set done and latch result, exc, excode, br, eret and target. Write-back to an invalid entry is ignored.
- The head is ready when `entry[head].valid & done`. Commit FSM states:
  - IDLE:
    - Ready head with exc: do not commit. Raise `exception_valid`, `redirect_pc`=EXC_VECTOR, `exc_code`=excode. Clear the ROB.
    - Ready head with eret: commit (commit_valid=0, ERET writes nothing). Raise `is_eret`, `redirect_pc`=target. Clear.
    - Ready head with br: commit normally, latch target, go to WAIT_DS.
    - Any other ready head: commit, head+1.
  - WAIT_DS (delay slot outstanding):
    - Ready head without exc: commit it, raise `branch_taken` with the latched target, clear, return to IDLE.
    - Ready head with exc: exception wins; the latched target is discarded; return to IDLE.
- `commit_valid = ready & ~exc & ~eret & (dst != 0) & ~pulse`. It is combinational from the head entry. The head advances on any retire, including dst=0.
- Clear means: all valid bits 0, head=tail=count=0, FSM to IDLE. It takes effect at the same edge that registers the pulse.
- count update: +1 on accepted alloc, −1 on retire; both may happen in one cycle. `rob_full` = (count == DEPTH), registered.

## Timing
- Reset values: all outputs 0, `alloc_id`=0, `redirect_pc`=0, head/tail/count 0, FSM IDLE.
- Allocation to entry visible: 1 cycle.
- Write-back at edge N → entry eligible to commit in cycle N+1.
- Commit is combinational in the cycle the head is ready. At most one retire per cycle.
- Redirect outputs are registered one-cycle pulses, issued in the cycle after the deciding head. During the pulse cycle the ROB is already empty, and alloc/wb inputs are ignored because they belong to the wrong path.
- Full boundary: with count==DEPTH, an alloc and a retire in the same cycle drop the alloc. `rob_full` falls on the next edge.
- Pointers wrap from DEPTH−1 to 0 without a bubble.
- Reset asserted mid-operation, including during WAIT_DS or a pulse: the next edge forces the reset state and the pulse is cancelled.

## Test plan
- Fill and drain: allocate 8 consecutive instructions with `rob_full` observed. Complete them in reverse order. Required: the 9th alloc is dropped, `rob_full`=1 after the 8th, and commits appear in order at ids 0..7, one per cycle, starting the cycle after id 0 completes.
- Wrap-around: allocate 6, retire 6, allocate 6 → `alloc_id` sequence 6,7,0,1,2,3; all six commit with correct `commit_pc`.
- Branch with delay slot: the branch at id 2 completes with `wb_br_taken`, target 32'h8000_0100, and the delay slot at id 3 completes. Required:
  - both commit;
  - `branch_taken`=1 for exactly one cycle, `redirect_pc`=32'h8000_0100, the cycle after id 3 commits;
  - count=0 afterwards, and an alloc during the pulse is dropped.
- Exception: id 1 completes with `wb_exc`, excode 5'd4. Required: id 0 commits, id 1 does not; `exception_valid` is pulsed with `redirect_pc`=32'hBFC0_0380 and `exc_code`=4.
- ERET: the head completes with `wb_eret`, target 32'h8000_2000 → `is_eret` pulse, `redirect_pc`=32'h8000_2000, commit_valid=0.
- Reset with 5 entries valid and in WAIT_DS → after the edge: count=0, `rob_full`=0, no pulse, `alloc_id`=0.
